// File: rtl/rr_mux_nto1_if.sv
// Channel-side and output-side signals of the round-robin N-to-1 mux.
// in_last exists only when RR_MUX_HOLD_EN is defined (packet-lock mode).
interface rr_mux_nto1_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_ready;

`ifdef RR_MUX_HOLD_EN
    logic [N_CH-1:0]        in_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/rr_mux_nto1.sv
// Round-robin N-to-1 mux with a registered, channel-tagged output stream.
// Define RR_MUX_HOLD_EN to lock the grant to one channel until in_last.
module rr_mux_nto1 #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_nto1_if.slave io_bus
);
    localparam int unsigned      SEL_W  = $clog2(N_CH);
    localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_free;
    logic              w_any;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_gnt;
    logic [SEL_W-1:0]  w_gnt_inc;
    logic [SEL_W-1:0]  w_ptr_d;
    logic [DATA_W-1:0] w_gnt_data;

    logic              w_rr_any;
    logic              w_hi_found;
    logic [SEL_W-1:0]  w_hi_idx;
    logic [SEL_W-1:0]  w_lo_idx;
    logic [SEL_W-1:0]  w_rr_gnt;

    assign w_free = !r_out_valid || io_bus.out_ready;

    // Lowest valid index >= ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_rr_any   = 1'b0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (io_bus.in_valid[i]) begin
                w_rr_any = 1'b1;
                w_lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(i);
                end
            end
        end
        w_rr_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Explicit wrap at N_CH so non-power-of-two channel counts stay in range.
    assign w_gnt_inc = (w_gnt == LastCh) ? '0 : w_gnt + SEL_W'(1);

    assign w_xfer = !rst && w_free && w_any;

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (SEL_W'(i) == w_gnt) begin
                w_gnt_data = io_bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        io_bus.in_ready = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (!rst && w_free && w_any && (SEL_W'(i) == w_gnt)) begin
                io_bus.in_ready[i] = 1'b1;
            end
        end
    end

`ifdef RR_MUX_HOLD_EN
    typedef enum logic {
        StIdle,
        StLocked
    } hold_state_e;

    hold_state_e      r_state;
    hold_state_e      w_state_d;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] w_lock_ch_d;
    logic             w_lock_valid;
    logic             w_gnt_last;

    always_comb begin
        w_lock_valid = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (SEL_W'(i) == r_lock_ch) begin
                w_lock_valid = io_bus.in_valid[i];
            end
        end
    end

    // While locked, only the locked channel may be granted, valid or not.
    assign w_gnt = (r_state == StLocked) ? r_lock_ch : w_rr_gnt;
    assign w_any = (r_state == StLocked) ? w_lock_valid : w_rr_any;

    always_comb begin
        w_gnt_last = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (SEL_W'(i) == w_gnt) begin
                w_gnt_last = io_bus.in_last[i];
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_lock_ch_d = r_lock_ch;
        w_ptr_d     = r_ptr;
        case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    if (w_gnt_last) begin
                        w_ptr_d = w_gnt_inc;
                    end else begin
                        w_state_d   = StLocked;
                        w_lock_ch_d = w_gnt;
                    end
                end
            end
            StLocked: begin
                if (w_xfer && w_gnt_last) begin
                    w_state_d = StIdle;
                    w_ptr_d   = w_gnt_inc;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_d;
            r_lock_ch <= w_lock_ch_d;
        end
    end
`else
    assign w_gnt   = w_rr_gnt;
    assign w_any   = w_rr_any;
    assign w_ptr_d = w_xfer ? w_gnt_inc : r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            r_ptr <= w_ptr_d;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt;
            end else if (io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Directed bench for rr_mux_nto1: a 4-channel and a 3-channel instance.
// Packet-lock vectors are compiled in when RR_MUX_HOLD_EN is defined.
module tb_rr_mux_nto1;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rr_mux_nto1_if #(.N_CH(4), .DATA_W(8)) bus_a ();
    rr_mux_nto1_if #(.N_CH(3), .DATA_W(8)) bus_b ();

    rr_mux_nto1 #(.N_CH(4), .DATA_W(8)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_a)
    );

    rr_mux_nto1 #(.N_CH(3), .DATA_W(8)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_a(input string tag, input logic v, input logic [7:0] d,
                               input logic [1:0] s);
        check({tag, "_valid"}, 32'(bus_a.out_valid), 32'(v));
        check({tag, "_data"},  32'(bus_a.out_data),  32'(d));
        check({tag, "_sel"},   32'(bus_a.out_sel),   32'(s));
    endtask

    int exp_sel4 [6] = '{0, 1, 2, 3, 0, 1};
    int exp_sel3 [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst             = 1'b1;
        bus_a.in_valid  = 4'b0100;
        bus_a.in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = '0;
        bus_b.in_data   = '0;
        bus_b.out_ready = 1'b1;
`ifdef RR_MUX_HOLD_EN
        bus_a.in_last   = '1;
        bus_b.in_last   = '1;
`endif

        // Reset, then single channel 2
        tick();
        tick();
        check("rst_in_ready", 32'(bus_a.in_ready), 32'h0);
        check_out_a("rst_out", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        check("single_in_ready", 32'(bus_a.in_ready), 32'b0100);
        tick();
        check_out_a("single_out", 1'b1, 8'hA5, 2'd2);
        bus_a.in_valid = '0;
        tick();
        check_out_a("single_drain", 1'b0, 8'hA5, 2'd2);

        // Full contention from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.in_valid = 4'b1111;
        bus_a.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out_a($sformatf("rot%0d", k), 1'b1, 8'(8'h10 + exp_sel4[k]),
                        2'(exp_sel4[k]));
        end

        // Backpressure: held beat is from channel 1, ptr now at 2
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_in_ready", k), 32'(bus_a.in_ready), 32'h0);
            tick();
            check_out_a($sformatf("stall%0d", k), 1'b1, 8'h11, 2'd1);
        end
        bus_a.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus_a.in_ready), 32'b1000);
        tick();
        check_out_a("release_a", 1'b1, 8'h13, 2'd3);
        #1;
        check("release_b_in_ready", 32'(bus_a.in_ready), 32'b0001);
        tick();
        check_out_a("release_b", 1'b1, 8'h10, 2'd0);
        bus_a.in_valid = '0;
        tick();
        check("idle_valid", 32'(bus_a.out_valid), 32'h0);

        // Reset mid-stream drops the held beat and rewinds ptr
        bus_a.in_valid = 4'b0100;
        tick();
        check_out_a("pre_rst", 1'b1, 8'h12, 2'd2);
        rst             = 1'b1;
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 4'b1010;
        #1;
        check("midrst_in_ready", 32'(bus_a.in_ready), 32'h0);
        tick();
        check_out_a("midrst_out", 1'b0, 8'h00, 2'd0);
        rst             = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        check("postrst_in_ready", 32'(bus_a.in_ready), 32'b0010);
        tick();
        check_out_a("postrst_out", 1'b1, 8'h11, 2'd1);
        bus_a.in_valid = '0;
        tick();

        // Three channels: ptr must wrap 2 -> 0
        bus_b.in_valid = 3'b111;
        bus_b.in_data  = {8'h22, 8'h21, 8'h20};
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("n3_sel%0d", k), 32'(bus_b.out_sel), 32'(exp_sel3[k]));
            check($sformatf("n3_data%0d", k), 32'(bus_b.out_data), 32'(8'h20 + exp_sel3[k]));
            check($sformatf("n3_no3_%0d", k), 32'(bus_b.out_sel == 2'd3), 32'h0);
        end
        bus_b.in_valid = '0;
        tick();

`ifdef RR_MUX_HOLD_EN
        // Channel 0 sends a 3-beat packet while channel 1 waits
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.in_valid = 4'b0011;
        bus_a.in_data  = {8'h00, 8'h00, 8'h40, 8'h30};
        bus_a.in_last  = 4'b0010;
        #1;
        check("pkt0_in_ready", 32'(bus_a.in_ready), 32'b0001);
        tick();
        check_out_a("pkt0", 1'b1, 8'h30, 2'd0);
        bus_a.in_data = {8'h00, 8'h00, 8'h40, 8'h31};
        #1;
        check("pkt1_in_ready", 32'(bus_a.in_ready), 32'b0001);
        tick();
        check_out_a("pkt1", 1'b1, 8'h31, 2'd0);
        bus_a.in_data = {8'h00, 8'h00, 8'h40, 8'h32};
        bus_a.in_last = 4'b0011;
        #1;
        check("pkt2_in_ready", 32'(bus_a.in_ready), 32'b0001);
        tick();
        check_out_a("pkt2", 1'b1, 8'h32, 2'd0);
        bus_a.in_valid = 4'b0010;
        #1;
        check("pkt_after_in_ready", 32'(bus_a.in_ready), 32'b0010);
        tick();
        check_out_a("pkt_after", 1'b1, 8'h40, 2'd1);
        bus_a.in_valid = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_nto1.md
# rr_mux_nto1

Round-robin N-to-1 multiplexer. It merges N independent valid/ready input channels into one registered output stream. Each output beat is tagged with its source channel index (`out_sel`), so the existing 1-to-N demultiplexer can route it back to the matching channel at the far end. The block sits on the transmit side of a channel-multiplexed link, upstream of the demux.

## Interface
- `N_CH`, default 4: number of input channels; legal range 2..16.
- `DATA_W`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: width of the channel tag. Derived; never overridden.

Ports:
- `clk`  in  1  Single clock. All logic is on the rising edge.
- `rst`  in  1  Reset: synchronous, active-high.
- `in_valid`  in  N_CH  Per-channel valid.
- `in_data`  in  N_CH*DATA_W  Channel i occupies bits `[i*DATA_W +: DATA_W]`.
- `in_ready`  out  N_CH  Per-channel ready. One-hot or zero.
- `in_last`  in  N_CH  Per-channel end-of-packet. Present only with `RR_MUX_HOLD_EN`.
- `out_valid`  out  1  Output register holds a beat.
- `out_data`  out  DATA_W  Registered data.
- `out_sel`  out  SEL_W  Source channel of the beat in `out_data`.
- `out_ready`  in  1  Downstream accepts the beat.

## Operation
- `free = !out_valid || out_ready`. The output register can load this cycle.
- Grant search order: `ptr`, `ptr+1`, … wrapping mod N_CH. The first channel with `in_valid=1` wins. `gnt` is its index.
- `in_ready[gnt] = free && any in_valid`. All other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of a different channel except through the arbitration.
- Transfer on channel i when `in_valid[i] && in_ready[i]`. On a transfer:
  - `out_data <= in_data[i]`
  - `out_sel <= i`
  - `out_valid <= 1`
  - `ptr <= (i+1) mod N_CH`
- No transfer and `out_ready=1`: `out_valid <= 0`. `out_data` and `out_sel` hold their values.
- No transfer and `out_ready=0`: all output registers hold.
- Simultaneous drain and load (`out_valid && out_ready` plus a transfer): the new beat replaces the old one in the same edge. No bubble.
- `ptr` advances only on a transfer. An idle cycle or a stalled cycle never moves it.
- Fairness: with all channels continuously valid and `out_ready=1`, grants rotate 0,1,…,N_CH-1,0. No channel waits more than N_CH-1 transfers.
- Width rule: `ptr+1` wraps explicitly at N_CH. It does not wrap at 2^SEL_W, so a non-power-of-two N_CH is correct.

## Timing
- Reset values, all applied synchronously:
  - `out_valid=0`, `out_data=0`, `out_sel=0`
  - `ptr=0`
  - hold state IDLE
- `in_ready` is forced to 0 while `rst=1`.
- Latency: a beat transferred at edge k is visible on `out_*` after edge k, and is accepted downstream at the first edge where `out_ready=1`.
- Throughput: 1 beat/cycle while `out_ready` stays high.
- Reset asserted mid-stream: the beat in the output register is dropped, and there is no transfer on that edge. The first grant after reset goes to the lowest-index valid channel.
- Upstream protocol: once `in_valid[i]` is asserted, it and `in_data[i]` stay stable until transferred. The block does not check this.

## Configuration
- `RR_MUX_HOLD_EN` undefined:
  - Arbitration is per beat.
  - `in_last` port is absent.
- `RR_MUX_HOLD_EN` defined: packet-lock mode, using a two-state FSM.
  - IDLE: round-robin as above. A transfer with `in_last[gnt]=0` moves the FSM to LOCKED and latches `lock_ch=gnt`.
  - LOCKED: the grant is forced to `lock_ch`. Every other `in_ready` bit is 0, even if `lock_ch` is not valid.
  - A LOCKED transfer with `in_last[lock_ch]=1` returns the FSM to IDLE, with `ptr=(lock_ch+1) mod N_CH`.
  - A single-beat packet (`in_last=1` on the first beat) stays in IDLE.
  - `ptr` does not advance on mid-packet beats.
  - `rst` returns the FSM to IDLE.

## Test plan
- Reset, single channel: `rst=1` for 2 cycles, then `in_valid=4'b0100`, `in_data[2]=8'hA5`, `out_ready=1`. Required: `in_ready=4'b0100` in cycle 0. One cycle later, `out_valid=1`, `out_data=8'hA5`, `out_sel=2`.
- Full contention: `in_valid=4'b1111` held, `out_ready=1`, data values 8'h10/8'h11/8'h12/8'h13 on channels 0-3. Required: `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Backpressure: beat on `out_sel=1` with `out_ready=0` for 3 cycles while channels 0 and 3 are valid. Required: `in_ready=0` during the stall, and `out_data` and `out_sel` are stable. After release, the next `out_sel` is 3, then 0.
- Non-power-of-two: `N_CH=3`, all channels valid. Required: `out_sel` sequence 0,1,2,0, and `out_sel` never equals 3.
- Reset mid-stream: assert `rst` while `out_valid=1`. Required: after the edge, `out_valid=0` and `out_sel=0`. With `in_valid=4'b1010` afterwards, the first grant is channel 1.
- With `RR_MUX_HOLD_EN`: channel 0 sends 3 beats with `in_last` pattern 0,0,1 while channel 1 is valid throughout. Required: `out_sel` sequence 0,0,0,1, and `in_ready[1]=0` during the packet.
